// File: rtl/cdc_pkg.sv
// Shared types and constants for the toggle-handshake clock-domain crossing blocks.
// Holds the controller state encoding, synchronizer depth and timeout defaults.
package cdc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } state_e;

    localparam int CDC_SYNC_STAGES     = 2;
    localparam int CDC_TIMEOUT_DEFAULT = 1024;

    // Counter must be able to hold TIMEOUT_CYC itself.
    function automatic int cnt_width(input int timeout_cyc);
        return $clog2(timeout_cyc + 1);
    endfunction

endpackage

// File: rtl/cdc_sync.sv
// Multi-flop synchronizer for a single level/toggle signal entering the clk domain.
// Depth is set by STAGES; the last flop is the only output.
module cdc_sync
    import cdc_pkg::*;
#(
    parameter int STAGES = CDC_SYNC_STAGES
) (
    input  logic clk,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] sync_q;

    // NOTE: synchronizer flops carry no reset; a reset mux in front of the first
    // stage would add logic in the metastability path, and the chain flushes itself.
    always_ff @(posedge clk) begin
        sync_q <= {sync_q[STAGES-2:0], din};
    end

    assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_xfer_tx.sv
// Source-side toggle req/ack controller for a multi-bit clock-domain crossing.
// Optional ack timeout with sticky err is enabled by defining CDC_XFER_TIMEOUT_EN.
module cdc_xfer_tx
    import cdc_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = CDC_TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              xfer_req,
    output logic [DATA_W-1:0] xfer_data,
    input  logic              xfer_ack_async,
    output logic              xfer_done,
    output logic              busy,
    output logic              err,
    input  logic              err_clr
);

    state_e            state_q, state_d;
    logic              req_q, req_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              done_q, done_d;
    logic              ack_s;
    logic              accept;
    logic              match;
    logic              timeout;

    cdc_sync #(
        .STAGES (CDC_SYNC_STAGES)
    ) u_ack_sync (
        .clk  (clk),
        .din  (xfer_ack_async),
        .dout (ack_s)
    );

    // Hold off acceptance during the done cycle so accepts are always separated.
    assign in_ready = (state_q == IDLE) && !done_q;
    assign accept   = in_valid && in_ready;
    assign match    = (state_q == WAIT) && (ack_s == req_q);

`ifdef CDC_XFER_TIMEOUT_EN
    localparam int              CNT_W    = cnt_width(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // A match in the same cycle as expiry takes priority over the error.
    assign timeout = (state_q == WAIT) && !match && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (accept) begin
            cnt_d = '0;
        end else if (state_q == WAIT) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (timeout) begin
            err_d = 1'b1;
        end else if ((state_q == ERR) && err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic        unused_err_clr;
    logic [31:0] unused_timeout_cyc;

    assign timeout            = 1'b0;
    assign err                = 1'b0;
    assign unused_err_clr     = err_clr;
    assign unused_timeout_cyc = 32'(TIMEOUT_CYC);
`endif

    // NOTE: every always_comb output gets a default first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d  = in_data;
                    req_d   = ~req_q;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (match) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (timeout) begin
                    state_d = ERR;
                end
            end
`ifdef CDC_XFER_TIMEOUT_EN
            ERR: begin
                if (err_clr) begin
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples the values
    // from before the edge; reset is synchronous, so it is tested inside the clocked block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign xfer_req  = req_q;
    assign xfer_data = data_q;
    assign xfer_done = done_q;
    assign busy      = (state_q == WAIT);

endmodule
